// File: rtl/cndm_dma_mux_pkg.sv
// Shared definitions for the DMA descriptor mux: status error codes and channel-index sizing.
package cndm_dma_mux_pkg;

    localparam int STS_ERR_W = 4;

    // Status codes are defined by the DMA engine; only OK is interpreted here.
    localparam logic [STS_ERR_W-1:0] STS_OK       = 4'd0;
    localparam logic [STS_ERR_W-1:0] STS_ERR_TLP  = 4'd1;
    localparam logic [STS_ERR_W-1:0] STS_ERR_TIMO = 4'd2;

    function automatic int ch_idx_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/cndm_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the
// winner only when the caller consumes the grant.
module cndm_rr_arbiter
    import cndm_dma_mux_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IDX_W = ch_idx_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             advance,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [PORTS-1:0] grant_onehot
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_lo_found;
    logic             w_hi_found;

    // Downward scan leaves the lowest requester overall and the lowest at/after the pointer.
    always_comb begin
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx   = IDX_W'(i);
                w_lo_found = 1'b1;
                if (i >= int'(r_ptr)) begin
                    w_hi_idx   = IDX_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign grant_valid = w_lo_found;
    assign grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < PORTS; i++) begin
            grant_onehot[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && grant_valid) begin
            r_ptr <= (grant_idx == IDX_W'(PORTS - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);
        end
    end

endmodule

// File: rtl/cndm_dma_desc_mux.sv
// Muxes CH descriptor request streams onto one DMA engine port and routes completion status
// back by the channel index carried in the upper tag bits.
module cndm_dma_desc_mux
    import cndm_dma_mux_pkg::*;
#(
    parameter  int CH         = 4,
    parameter  int SRC_ADDR_W = 64,
    parameter  int DST_ADDR_W = 16,
    parameter  int SEL_W      = 4,
    parameter  int LEN_W      = 20,
    parameter  int TAG_W      = 8,
    parameter  int MAX_OUT    = 16,
    localparam int CL_CH      = ch_idx_width(CH),
    localparam int CH_TAG_W   = TAG_W - CL_CH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH*SRC_ADDR_W-1:0] s_req_src_addr,
    input  logic [CH*DST_ADDR_W-1:0] s_req_dst_addr,
    input  logic [CH*SEL_W-1:0]      s_req_sel,
    input  logic [CH*LEN_W-1:0]      s_req_len,
    input  logic [CH*CH_TAG_W-1:0]   s_req_tag,
    input  logic [CH-1:0]            s_req_valid,
    output logic [CH-1:0]            s_req_ready,
    output logic [SRC_ADDR_W-1:0]    m_req_src_addr,
    output logic [DST_ADDR_W-1:0]    m_req_dst_addr,
    output logic [SEL_W-1:0]         m_req_sel,
    output logic [LEN_W-1:0]         m_req_len,
    output logic [TAG_W-1:0]         m_req_tag,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    input  logic [TAG_W-1:0]         s_sts_tag,
    input  logic [STS_ERR_W-1:0]     s_sts_error,
    input  logic                     s_sts_valid,
    output logic [CH_TAG_W-1:0]      m_sts_tag,
    output logic [STS_ERR_W-1:0]     m_sts_error,
    output logic [CH-1:0]            m_sts_valid,
    input  logic [CH-1:0]            ch_enable,
    output logic [CH*8-1:0]          stat_outstanding,
    output logic                     stat_err_unexp
);

    logic [7:0]            r_cnt [CH];
    logic                  r_m_valid;
    logic [SRC_ADDR_W-1:0] r_src;
    logic [DST_ADDR_W-1:0] r_dst;
    logic [SEL_W-1:0]      r_sel;
    logic [LEN_W-1:0]      r_len;
    logic [TAG_W-1:0]      r_tag;
    logic [CH-1:0]         r_sts_valid;
    logic [CH_TAG_W-1:0]   r_sts_tag;
    logic [STS_ERR_W-1:0]  r_sts_err;
    logic                  r_err_unexp;

    logic [CH-1:0]         w_elig;
    logic [CH-1:0]         w_arb_onehot;
    logic [CL_CH-1:0]      w_arb_idx;
    logic                  w_arb_valid;
    logic                  w_grant;
    logic [SRC_ADDR_W-1:0] w_src;
    logic [DST_ADDR_W-1:0] w_dst;
    logic [SEL_W-1:0]      w_sel;
    logic [LEN_W-1:0]      w_len;
    logic [CH_TAG_W-1:0]   w_tag;
    logic [CL_CH-1:0]      w_sts_ch;
    logic [CH-1:0]         w_sts_hit;
    logic [CH-1:0]         w_dec;
    logic                  w_sts_cnt_zero;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < CH; i++) begin
            w_elig[i] = s_req_valid[i] && ch_enable[i] && (r_cnt[i] < 8'(MAX_OUT));
        end
    end

    cndm_rr_arbiter #(.PORTS(CH)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (w_elig),
        .advance      (w_grant),
        .grant_valid  (w_arb_valid),
        .grant_idx    (w_arb_idx),
        .grant_onehot (w_arb_onehot)
    );

    // rst gates the grant so no handshake can complete while reset is held.
    assign w_grant     = w_arb_valid && (!r_m_valid || m_req_ready) && !rst;
    assign s_req_ready = w_grant ? w_arb_onehot : '0;

    always_comb begin
        w_src = '0;
        w_dst = '0;
        w_sel = '0;
        w_len = '0;
        w_tag = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_arb_onehot[i]) begin
                w_src = s_req_src_addr[i*SRC_ADDR_W +: SRC_ADDR_W];
                w_dst = s_req_dst_addr[i*DST_ADDR_W +: DST_ADDR_W];
                w_sel = s_req_sel[i*SEL_W +: SEL_W];
                w_len = s_req_len[i*LEN_W +: LEN_W];
                w_tag = s_req_tag[i*CH_TAG_W +: CH_TAG_W];
            end
        end
    end

    // An index beyond CH-1 matches no channel, so it is dropped and flagged below.
    assign w_sts_ch = s_sts_tag[TAG_W-1 -: CL_CH];

    always_comb begin
        w_sts_hit      = '0;
        w_dec          = '0;
        w_sts_cnt_zero = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (s_sts_valid && (w_sts_ch == CL_CH'(i))) begin
                w_sts_hit[i] = 1'b1;
                if (r_cnt[i] == 8'd0) begin
                    w_sts_cnt_zero = 1'b1;
                end else begin
                    w_dec[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_sel       <= '0;
            r_len       <= '0;
            r_tag       <= '0;
            r_sts_valid <= '0;
            r_sts_tag   <= '0;
            r_sts_err   <= '0;
            r_err_unexp <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_m_valid <= 1'b1;
                r_src     <= w_src;
                r_dst     <= w_dst;
                r_sel     <= w_sel;
                r_len     <= w_len;
                r_tag     <= {w_arb_idx, w_tag};
            end else if (m_req_ready) begin
                r_m_valid <= 1'b0;
            end
            r_sts_valid <= w_sts_hit;
            if (s_sts_valid) begin
                r_sts_tag <= s_sts_tag[CH_TAG_W-1:0];
                r_sts_err <= s_sts_error;
            end
            r_err_unexp <= s_sts_valid && ((w_sts_hit == '0) || w_sts_cnt_zero);
            for (int i = 0; i < CH; i++) begin
                case ({w_grant && w_arb_onehot[i], w_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 8'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 8'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign m_req_valid    = r_m_valid;
    assign m_req_src_addr = r_src;
    assign m_req_dst_addr = r_dst;
    assign m_req_sel      = r_sel;
    assign m_req_len      = r_len;
    assign m_req_tag      = r_tag;
    assign m_sts_valid    = r_sts_valid;
    assign m_sts_tag      = r_sts_tag;
    assign m_sts_error    = r_sts_err;
    assign stat_err_unexp = r_err_unexp;

    always_comb begin
        stat_outstanding = '0;
        for (int i = 0; i < CH; i++) begin
            stat_outstanding[i*8 +: 8] = r_cnt[i];
        end
    end

endmodule

// File: tb/tb_cndm_dma_desc_mux.sv
// Directed bench: a 4-channel mux with MAX_OUT=2 driven from a vector table plus hand
// sequences, and a 3-channel mux for non-power-of-two wrap and out-of-range status.
module tb_cndm_dma_desc_mux;
    import cndm_dma_mux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [255:0] a_src;
    logic [63:0]  a_dst;
    logic [15:0]  a_sel;
    logic [79:0]  a_len;
    logic [23:0]  a_tag;
    logic [3:0]   a_valid, a_ready, a_en, a_m_sts_valid;
    logic [63:0]  a_m_src;
    logic [15:0]  a_m_dst;
    logic [3:0]   a_m_sel;
    logic [19:0]  a_m_len;
    logic [7:0]   a_m_tag, a_sts_tag;
    logic         a_m_valid, a_mrdy, a_sts_valid, a_err;
    logic [3:0]   a_sts_err, a_m_sts_err;
    logic [5:0]   a_m_sts_tag;
    logic [31:0]  a_stat;

    // 3-channel instance
    logic [191:0] b_src;
    logic [47:0]  b_dst;
    logic [11:0]  b_sel;
    logic [59:0]  b_len;
    logic [17:0]  b_tag;
    logic [2:0]   b_valid, b_ready, b_en, b_m_sts_valid;
    logic [63:0]  b_m_src;
    logic [15:0]  b_m_dst;
    logic [3:0]   b_m_sel;
    logic [19:0]  b_m_len;
    logic [7:0]   b_m_tag, b_sts_tag;
    logic         b_m_valid, b_mrdy, b_sts_valid, b_err;
    logic [3:0]   b_sts_err, b_m_sts_err;
    logic [5:0]   b_m_sts_tag;
    logic [23:0]  b_stat;

    cndm_dma_desc_mux #(.CH(4), .MAX_OUT(2)) u_dut (
        .clk(clk), .rst(rst),
        .s_req_src_addr(a_src), .s_req_dst_addr(a_dst), .s_req_sel(a_sel),
        .s_req_len(a_len), .s_req_tag(a_tag), .s_req_valid(a_valid), .s_req_ready(a_ready),
        .m_req_src_addr(a_m_src), .m_req_dst_addr(a_m_dst), .m_req_sel(a_m_sel),
        .m_req_len(a_m_len), .m_req_tag(a_m_tag), .m_req_valid(a_m_valid), .m_req_ready(a_mrdy),
        .s_sts_tag(a_sts_tag), .s_sts_error(a_sts_err), .s_sts_valid(a_sts_valid),
        .m_sts_tag(a_m_sts_tag), .m_sts_error(a_m_sts_err), .m_sts_valid(a_m_sts_valid),
        .ch_enable(a_en), .stat_outstanding(a_stat), .stat_err_unexp(a_err)
    );

    cndm_dma_desc_mux #(.CH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_req_src_addr(b_src), .s_req_dst_addr(b_dst), .s_req_sel(b_sel),
        .s_req_len(b_len), .s_req_tag(b_tag), .s_req_valid(b_valid), .s_req_ready(b_ready),
        .m_req_src_addr(b_m_src), .m_req_dst_addr(b_m_dst), .m_req_sel(b_m_sel),
        .m_req_len(b_m_len), .m_req_tag(b_m_tag), .m_req_valid(b_m_valid), .m_req_ready(b_mrdy),
        .s_sts_tag(b_sts_tag), .s_sts_error(b_sts_err), .s_sts_valid(b_sts_valid),
        .m_sts_tag(b_m_sts_tag), .m_sts_error(b_m_sts_err), .m_sts_valid(b_m_sts_valid),
        .ch_enable(b_en), .stat_outstanding(b_stat), .stat_err_unexp(b_err)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  en;
        logic        mrdy;
        logic        stsv;
        logic [7:0]  ststag;
        logic [3:0]  e_sready;
        logic        e_mvalid;
        logic [7:0]  e_mtag;
        logic [3:0]  e_stsv;
        logic [5:0]  e_ststag;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [3:0] valid, en, input logic mrdy, stsv,
                                input logic [7:0] ststag, input logic [3:0] e_sready,
                                input logic e_mvalid, input logic [7:0] e_mtag,
                                input logic [3:0] e_stsv, input logic [5:0] e_ststag,
                                input logic e_err, input logic [31:0] e_cnt);
        vec_t v;
        v.valid = valid; v.en = en; v.mrdy = mrdy; v.stsv = stsv; v.ststag = ststag;
        v.e_sready = e_sready; v.e_mvalid = e_mvalid; v.e_mtag = e_mtag; v.e_stsv = e_stsv;
        v.e_ststag = e_ststag; v.e_err = e_err; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Checks the A-side request fields against the per-channel constants for channel idx.
    task automatic check_a_fields(input string name, input int idx);
        check({name, " len"}, 64'(a_m_len), 64'(64 * (idx + 1)));
        check({name, " src"}, a_m_src, 64'h1000_0000 + 64'(idx));
        check({name, " dst"}, 64'(a_m_dst), 64'(16'h0100 * idx));
        check({name, " sel"}, 64'(a_m_sel), 64'(idx + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [5:0] a_tags [4];
        logic [5:0] b_tags [3];
        logic [2:0] b_exp_rdy [4];
        logic [7:0] b_exp_tag [4];
        vec_t v;

        a_tags[0] = 6'h10; a_tags[1] = 6'h11; a_tags[2] = 6'h05; a_tags[3] = 6'h13;
        b_tags[0] = 6'h01; b_tags[1] = 6'h02; b_tags[2] = 6'h07;
        for (int i = 0; i < 4; i++) begin
            a_src[i*64 +: 64] = 64'h1000_0000 + 64'(i);
            a_dst[i*16 +: 16] = 16'(16'h0100 * i);
            a_sel[i*4 +: 4]   = 4'(i + 1);
            a_len[i*20 +: 20] = 20'(64 * (i + 1));
            a_tag[i*6 +: 6]   = a_tags[i];
        end
        for (int i = 0; i < 3; i++) begin
            b_src[i*64 +: 64] = 64'h2000_0000 + 64'(i);
            b_dst[i*16 +: 16] = 16'(i);
            b_sel[i*4 +: 4]   = 4'(i);
            b_len[i*20 +: 20] = 20'(8 * (i + 1));
            b_tag[i*6 +: 6]   = b_tags[i];
        end
        a_valid = 4'hF; a_en = 4'hF; a_mrdy = 1'b1;
        a_sts_valid = 1'b0; a_sts_tag = '0; a_sts_err = STS_OK;
        b_valid = '0; b_en = 3'b111; b_mrdy = 1'b1;
        b_sts_valid = 1'b0; b_sts_tag = '0; b_sts_err = STS_OK;

        // Reset state, with requests already presented
        repeat (2) @(posedge clk);
        #1;
        check("reset m_req_valid", 64'(a_m_valid), 64'd0);
        check("reset s_req_ready", 64'(a_ready), 64'd0);
        check("reset m_sts_valid", 64'(a_m_sts_valid), 64'd0);
        check("reset counts", 64'(a_stat), 64'd0);
        check("reset err_unexp", 64'(a_err), 64'd0);
        a_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request, status return, fairness, limit, error, enable
        vecs.push_back(mk(4'b0100, 4'hF, 1, 0, 8'h00, 4'b0100, 1, 8'h85, 4'b0000, 6'h00, 0, 32'h0001_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h85, 4'b0000, 0, 8'h00, 4'b0100, 6'h05, 0, 32'h0000_0000));
        vecs.push_back(mk(4'b1000, 4'hF, 1, 0, 8'h00, 4'b1000, 1, 8'hD3, 4'b0000, 6'h00, 0, 32'h0100_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'hD3, 4'b0000, 0, 8'h00, 4'b1000, 6'h13, 0, 32'h0000_0000));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0001, 1, 8'h10, 4'b0000, 6'h00, 0, 32'h0000_0001));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0010, 1, 8'h51, 4'b0000, 6'h00, 0, 32'h0000_0101));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0100, 1, 8'h85, 4'b0000, 6'h00, 0, 32'h0001_0101));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b1000, 1, 8'hD3, 4'b0000, 6'h00, 0, 32'h0101_0101));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0001, 1, 8'h10, 4'b0000, 6'h00, 0, 32'h0101_0102));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0010, 1, 8'h51, 4'b0000, 6'h00, 0, 32'h0101_0202));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0100, 1, 8'h85, 4'b0000, 6'h00, 0, 32'h0102_0202));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b1000, 1, 8'hD3, 4'b0000, 6'h00, 0, 32'h0202_0202));
        vecs.push_back(mk(4'b1111, 4'hF, 1, 0, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 6'h00, 0, 32'h0202_0202));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h10, 4'b0000, 0, 8'h00, 4'b0001, 6'h10, 0, 32'h0202_0201));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h10, 4'b0000, 0, 8'h00, 4'b0001, 6'h10, 0, 32'h0202_0200));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h85, 4'b0000, 0, 8'h00, 4'b0100, 6'h05, 0, 32'h0201_0200));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h85, 4'b0000, 0, 8'h00, 4'b0100, 6'h05, 0, 32'h0200_0200));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'hD3, 4'b0000, 0, 8'h00, 4'b1000, 6'h13, 0, 32'h0100_0200));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'hD3, 4'b0000, 0, 8'h00, 4'b1000, 6'h13, 0, 32'h0000_0200));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 0, 8'h00, 4'b1000, 1, 8'hD3, 4'b0000, 6'h00, 0, 32'h0100_0200));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 1, 8'hD3, 4'b1000, 1, 8'hD3, 4'b1000, 6'h13, 0, 32'h0100_0200));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 1, 8'h51, 4'b1000, 1, 8'hD3, 4'b0010, 6'h11, 0, 32'h0200_0100));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 0, 8'h00, 4'b0010, 1, 8'h51, 4'b0000, 6'h00, 0, 32'h0200_0200));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h51, 4'b0000, 0, 8'h00, 4'b0010, 6'h11, 0, 32'h0200_0100));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h51, 4'b0000, 0, 8'h00, 4'b0010, 6'h11, 0, 32'h0200_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'hD3, 4'b0000, 0, 8'h00, 4'b1000, 6'h13, 0, 32'h0100_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'hD3, 4'b0000, 0, 8'h00, 4'b1000, 6'h13, 0, 32'h0000_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 1, 8'h10, 4'b0000, 0, 8'h00, 4'b0001, 6'h10, 1, 32'h0000_0000));
        vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 6'h00, 0, 32'h0000_0000));
        vecs.push_back(mk(4'b0001, 4'hE, 1, 0, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 6'h00, 0, 32'h0000_0000));

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            a_valid = v.valid; a_en = v.en; a_mrdy = v.mrdy;
            a_sts_valid = v.stsv; a_sts_tag = v.ststag;
            #1;
            check($sformatf("v%0d s_req_ready", k), 64'(a_ready), 64'(v.e_sready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d m_req_valid", k), 64'(a_m_valid), 64'(v.e_mvalid));
            if (v.e_mvalid) begin
                check($sformatf("v%0d m_req_tag", k), 64'(a_m_tag), 64'(v.e_mtag));
                check_a_fields($sformatf("v%0d", k), int'(v.e_mtag[7:6]));
            end
            check($sformatf("v%0d m_sts_valid", k), 64'(a_m_sts_valid), 64'(v.e_stsv));
            if (v.e_stsv != 4'b0000)
                check($sformatf("v%0d m_sts_tag", k), 64'(a_m_sts_tag), 64'(v.e_ststag));
            check($sformatf("v%0d err_unexp", k), 64'(a_err), 64'(v.e_err));
            check($sformatf("v%0d counts", k), 64'(a_stat), 64'(v.e_cnt));
        end

        // Backpressure: one grant to ch0, then held for 5 cycles; ch1 follows
        a_en = 4'hF; a_valid = 4'b0011; a_mrdy = 1'b0; a_sts_valid = 1'b0;
        #1;
        check("bp first s_req_ready", 64'(a_ready), 64'b0001);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp c%0d m_req_valid", c), 64'(a_m_valid), 64'd1);
            check($sformatf("bp c%0d m_req_tag", c), 64'(a_m_tag), 64'h10);
            check_a_fields($sformatf("bp c%0d", c), 0);
            if (c < 4) check($sformatf("bp c%0d s_req_ready", c), 64'(a_ready), 64'd0);
        end
        check("bp count", 64'(a_stat), 64'h0000_0001);
        a_mrdy = 1'b1;
        #1;
        check("bp resume s_req_ready", 64'(a_ready), 64'b0010);
        @(posedge clk);
        #1;
        check("bp resume m_req_tag", 64'(a_m_tag), 64'h51);
        check("bp resume counts", 64'(a_stat), 64'h0000_0101);
        a_valid = '0; a_sts_valid = 1'b1; a_sts_tag = 8'h10;
        @(posedge clk);
        #1;
        a_sts_tag = 8'h51;
        @(posedge clk);
        #1;
        a_sts_valid = 1'b0;
        check("bp drained counts", 64'(a_stat), 64'd0);

        // Async reset mid-burst
        a_valid = 4'hF;
        repeat (8) @(posedge clk);
        #1;
        check("pre-reset counts", 64'(a_stat), 64'h0202_0202);
        check("pre-reset m_req_valid", 64'(a_m_valid), 64'd1);
        a_mrdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst m_req_valid", 64'(a_m_valid), 64'd0);
        check("async rst s_req_ready", 64'(a_ready), 64'd0);
        check("async rst counts", 64'(a_stat), 64'd0);
        check("async rst m_sts_valid", 64'(a_m_sts_valid), 64'd0);
        check("async rst err_unexp", 64'(a_err), 64'd0);
        a_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        a_valid = 4'hF; a_mrdy = 1'b1;
        #1;
        check("post-reset rr restart", 64'(a_ready), 64'b0001);
        @(posedge clk);
        #1;
        a_valid = '0;
        check("post-reset m_req_tag", 64'(a_m_tag), 64'h10);
        // late status for a channel whose count was cleared
        a_sts_valid = 1'b1; a_sts_tag = 8'hD3; a_sts_err = 4'hA;
        @(posedge clk);
        #1;
        a_sts_valid = 1'b0;
        check("late sts m_sts_valid", 64'(a_m_sts_valid), 64'b1000);
        check("late sts error code", 64'(a_m_sts_err), 64'hA);
        check("late sts err_unexp", 64'(a_err), 64'd1);
        check("late sts counts", 64'(a_stat), 64'h0000_0001);
        check("late sts m_req_valid", 64'(a_m_valid), 64'd0);

        // 3-channel instance: modulo-3 rotation and out-of-range status index
        b_exp_rdy[0] = 3'b001; b_exp_rdy[1] = 3'b010; b_exp_rdy[2] = 3'b100; b_exp_rdy[3] = 3'b001;
        b_exp_tag[0] = 8'h01;  b_exp_tag[1] = 8'h42;  b_exp_tag[2] = 8'h87;  b_exp_tag[3] = 8'h01;
        b_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("ch3 g%0d s_req_ready", c), 64'(b_ready), 64'(b_exp_rdy[c]));
            @(posedge clk);
            #1;
            check($sformatf("ch3 g%0d m_req_tag", c), 64'(b_m_tag), 64'(b_exp_tag[c]));
        end
        b_valid = '0;
        check("ch3 counts", 64'(b_stat), 64'h01_01_02);
        b_sts_valid = 1'b1; b_sts_tag = 8'hC1;
        @(posedge clk);
        #1;
        b_sts_valid = 1'b0;
        check("ch3 bad idx m_sts_valid", 64'(b_m_sts_valid), 64'd0);
        check("ch3 bad idx err_unexp", 64'(b_err), 64'd1);
        check("ch3 bad idx counts", 64'(b_stat), 64'h01_01_02);
        @(posedge clk);
        #1;
        check("ch3 err pulse end", 64'(b_err), 64'd0);
        b_sts_valid = 1'b1; b_sts_tag = 8'h87;
        @(posedge clk);
        #1;
        b_sts_valid = 1'b0;
        check("ch3 sts m_sts_valid", 64'(b_m_sts_valid), 64'b100);
        check("ch3 sts m_sts_tag", 64'(b_m_sts_tag), 64'h07);
        check("ch3 sts counts", 64'(b_stat), 64'h00_01_02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
